// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM state encoding and default frame geometry.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int UART_OVERSAMPLE_DEF = 16;
  localparam int UART_DATA_BITS_DEF  = 8;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous input; both flops reset to RST_VAL.
module uart_rx_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive framing: start qualification, mid-bit sampling, stop check, valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop (and the parity_err port).
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEF,
  parameter int DATA_BITS  = UART_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_next;
  logic [TW-1:0]        r_tick_cnt;
  logic [BW-1:0]        r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_ferr;
  logic                 r_ovr;
  logic                 w_rx_s;
  logic                 w_half;
  logic                 w_wrap;
  logic                 w_busy;
  logic                 w_stop_smp;
  logic                 w_good;
  logic                 w_ferr;
  logic                 w_load;
  logic                 w_ovr;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_perr;
  logic                 w_perr;
`endif

  uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  assign w_half = tick && (r_tick_cnt == HALF_M1);
  assign w_wrap = tick && (r_tick_cnt == FULL_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RX_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:   if (tick && !w_rx_s) w_next = RX_START;
      RX_START:  if (w_half) w_next = w_rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (w_wrap && (r_bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
          w_next = RX_PARITY;
`else
          w_next = RX_STOP;
`endif
        end
      RX_PARITY: if (w_wrap) w_next = RX_STOP;
      RX_STOP:   if (w_wrap) w_next = RX_IDLE;
      default:   w_next = RX_IDLE;
    endcase
  end

  // A good frame loads only if the output slot is free or being drained this cycle.
  always_comb begin
    w_busy     = (r_state != RX_IDLE);
    w_stop_smp = (r_state == RX_STOP) && w_wrap;
    w_ferr     = w_stop_smp && !w_rx_s;
`ifdef UART_RX_PARITY_EN
    w_perr     = w_stop_smp && w_rx_s && r_par_bad;
    w_good     = w_stop_smp && w_rx_s && !r_par_bad;
`else
    w_good     = w_stop_smp && w_rx_s;
`endif
    w_load     = w_good && (!r_valid || rx_ready);
    w_ovr      = w_good && r_valid && !rx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
`ifdef UART_RX_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      case (r_state)
        RX_IDLE: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
        RX_START: begin
          if (w_half) begin
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end else if (tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        RX_DATA, RX_PARITY, RX_STOP: begin
          if (w_wrap) begin
            r_tick_cnt <= '0;
            if (r_state == RX_DATA) begin
              r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
`ifdef UART_RX_PARITY_EN
            if (r_state == RX_PARITY) r_par_bad <= (^r_shift) ^ w_rx_s;
`endif
          end else if (tick) begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
          end
        end
        default: begin
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_ferr <= w_ferr;
      r_ovr  <= w_ovr;
`ifdef UART_RX_PARITY_EN
      r_perr <= w_perr;
`endif
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (r_valid && rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;
  assign busy      = w_busy;
`ifdef UART_RX_PARITY_EN
  assign parity_err = r_perr;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: 16x oversample, one tick every 4 clk, frames driven tick by tick.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Falling edge driven at step 0 is seen at step 1; stop sample lands 8 + 16*(NB-1) steps later.
  localparam int STOP_STEP = 9 + 16 * (NB - 1);

  uart_rx_ctrl #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_ferr = 0;
  int n_ovr  = 0;
  int n_acc  = 0;
  int n_perr = 0;
  logic [7:0] last_acc = 8'h00;

  always begin
    @(negedge clk);
    #2;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    if (rx_valid && rx_ready) begin
      n_acc++;
      last_acc = rx_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step_tick(input logic b, input logic rdy_tick, input logic rdy_rest);
    @(negedge clk);
    tick = 1'b1;
    rx = b;
    rx_ready = rdy_tick;
    @(negedge clk);
    tick = 1'b0;
    rx_ready = rdy_rest;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step_tick(1'b1, rdy, rdy);
  endtask

  function automatic logic [15:0] mk(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {5'b0, stop, ^d, d, 1'b0};
`else
    return {6'b0, stop, d, 1'b0};
`endif
  endfunction

`ifdef UART_RX_PARITY_EN
  function automatic logic [15:0] mk_p(input logic [7:0] d, input logic par, input logic stop);
    return {5'b0, stop, par, d, 1'b0};
  endfunction
`endif

  task automatic send_frame(input logic [15:0] fr, input logic rdy, input int pulse_step);
    for (int k = 0; k < NB * 16; k++)
      step_tick(fr[k/16], rdy | (k == pulse_step), rdy);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         exp_acc;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int a, f, o, p;
    logic [15:0] fr;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h3C, 1'b1, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 0};
    vecs[5] = '{8'h80, 1'b0, 0, 1};
    vecs[6] = '{8'h01, 1'b1, 1, 0};

    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4, 1'b1);

    for (int i = 0; i < 7; i++) begin
      a = n_acc; f = n_ferr; o = n_ovr;
      send_frame(mk(vecs[i].d, vecs[i].stop), 1'b1, -1);
      idle(20, 1'b1);
      check($sformatf("vec%0d_ferr", i), n_ferr - f, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), n_ovr - o, 0);
      check($sformatf("vec%0d_acc", i), n_acc - a, vecs[i].exp_acc);
      if (vecs[i].exp_acc == 1) check($sformatf("vec%0d_data", i), last_acc, vecs[i].d);
      check($sformatf("vec%0d_busy", i), busy, 0);
    end

    // Short low pulse: start qualification rejects it.
    f = n_ferr; a = n_acc;
    repeat (4) step_tick(1'b0, 1'b1, 1'b1);
    check("glitch_busy_hi", busy, 1);
    idle(8, 1'b1);
    check("glitch_busy_lo", busy, 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", n_ferr - f, 0);
    check("glitch_acc", n_acc - a, 0);

    // Two frames with no consumer: second one is dropped.
    o = n_ovr;
    send_frame(mk(8'h11, 1'b1), 1'b0, -1);
    send_frame(mk(8'h22, 1'b1), 1'b0, -1);
    idle(4, 1'b0);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_pulses", n_ovr - o, 1);
    step_tick(1'b1, 1'b1, 1'b0);
    idle(2, 1'b0);
    check("ovr_drained", rx_valid, 0);

    // Consumer accepts in the exact stop-sample cycle of the second frame.
    o = n_ovr;
    send_frame(mk(8'h11, 1'b1), 1'b0, -1);
    check("same_first_valid", rx_valid, 1);
    check("same_first_data", rx_data, 8'h11);
    send_frame(mk(8'h22, 1'b1), 1'b0, STOP_STEP);
    idle(4, 1'b0);
    check("same_valid", rx_valid, 1);
    check("same_data", rx_data, 8'h22);
    check("same_no_ovr", n_ovr - o, 0);
    step_tick(1'b1, 1'b1, 1'b0);
    idle(2, 1'b1);

    // Reset during data bit 3 of 0xFF with a byte already held.
    send_frame(mk(8'hC3, 1'b1), 1'b0, -1);
    idle(2, 1'b0);
    check("pre_rst_valid", rx_valid, 1);
    fr = mk(8'hFF, 1'b1);
    for (int k = 0; k < 70; k++) step_tick(fr[k/16], 1'b0, 1'b0);
    check("pre_rst_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ferr", frame_err, 0);
    check("mid_rst_ovr", overrun, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    a = n_acc; f = n_ferr;
    idle(20, 1'b1);
    check("post_rst_no_acc", n_acc - a, 0);
    send_frame(mk(8'h5A, 1'b1), 1'b1, -1);
    idle(20, 1'b1);
    check("post_rst_acc", n_acc - a, 1);
    check("post_rst_data", last_acc, 8'h5A);
    check("post_rst_ferr", n_ferr - f, 0);

`ifdef UART_RX_PARITY_EN
    p = n_perr; a = n_acc; f = n_ferr;
    send_frame(mk_p(8'h07, 1'b0, 1'b1), 1'b1, -1);
    idle(20, 1'b1);
    check("par_bad_perr", n_perr - p, 1);
    check("par_bad_acc", n_acc - a, 0);
    check("par_bad_ferr", n_ferr - f, 0);
    p = n_perr; a = n_acc;
    send_frame(mk_p(8'h07, 1'b1, 1'b1), 1'b1, -1);
    idle(20, 1'b1);
    check("par_ok_perr", n_perr - p, 0);
    check("par_ok_acc", n_acc - a, 1);
    check("par_ok_data", last_acc, 8'h07);
`else
    p = n_perr;
    check("no_parity_pulses", p, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
